// File: rtl/mca_folded_estimator_if.sv
// Sample-request handshake and coefficient/control bus of the folded FIR estimator.
// H_matrix[j][n] is the coefficient of tap j, channel n; S_matrix[n][j] is its sign-select bit.
interface mca_folded_estimator_if #(
  parameter int K                 = 256,
  parameter int N                 = 8,
  parameter int WIDTH_COEFFICIENT = 32,
  parameter int WIDTH_OUT         = 32
);
  logic                                            start;
  logic signed [K-1:0][N-1:0][WIDTH_COEFFICIENT-1:0] H_matrix;
  logic        [N-1:0][K-1:0]                       S_matrix;
  logic                                            busy;
  logic signed [WIDTH_OUT-1:0]                     sample;
  logic                                            sample_valid;

  modport master (output start, H_matrix, S_matrix, input busy, sample, sample_valid);
  modport slave  (input start, H_matrix, S_matrix, output busy, sample, sample_valid);
endinterface

// File: rtl/mca_folded_estimator.sv
// Time-folded FIR estimator: accumulates LANES taps of every channel per cycle as +/-H
// chosen by a snapshot of S, then narrows the growth-safe sum by wrap or saturation.
module mca_folded_estimator #(
  parameter int K                 = 256,
  parameter int N                 = 8,
  parameter int WIDTH_COEFFICIENT = 32,
  parameter int LANES             = 4,
  parameter int WIDTH_OUT         = 32,
  parameter bit SATURATE          = 1'b0
) (
  input  logic                    clk,
  input  logic                    resetn,
  mca_folded_estimator_if.slave   bus
);
  localparam int F         = K / LANES;
  localparam int WIDTH_ACC = WIDTH_COEFFICIENT + $clog2(K * N) + 1;
  localparam int GW        = (F > 1) ? $clog2(F) : 1;
  localparam int JW        = (K > 1) ? $clog2(K) : 1;
  localparam int NT        = N * LANES;
  localparam int TL        = (NT > 1) ? $clog2(NT) : 0;
  localparam int P         = 1 << TL;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_OUT   = 2'd2
  } state_t;

  state_t                        state_r;
  logic [GW-1:0]                 g_r;
  logic signed [WIDTH_ACC-1:0]   acc_r;
  logic [N-1:0][K-1:0]           s_snap_r;
  logic                          busy_r;
  logic                          valid_r;
  logic signed [WIDTH_OUT-1:0]   sample_r;
  logic signed [WIDTH_ACC-1:0]   group_sum_s;
  logic signed [WIDTH_OUT-1:0]   narrow_s;

  // Balanced adder tree: level 0 holds the signed terms (zero-padded to a power of two),
  // each higher level halves the node count until a single group sum remains.
  for (genvar lv = 0; lv <= TL; lv++) begin : g_lvl
    logic signed [WIDTH_ACC-1:0] node_s [P >> lv];
    if (lv == 0) begin : g_leaf
      for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [JW-1:0] j_s;
        assign j_s = JW'(int'(g_r) * LANES + l);
        for (genvar n = 0; n < N; n++) begin : g_ch
          logic signed [WIDTH_ACC-1:0] h_ext_s;
          // Extend before negating so the most negative coefficient negates exactly.
          assign h_ext_s         = WIDTH_ACC'($signed(bus.H_matrix[j_s][n]));
          assign node_s[l*N + n] = s_snap_r[n][j_s] ? h_ext_s : -h_ext_s;
        end
      end
      for (genvar p = NT; p < P; p++) begin : g_pad
        assign node_s[p] = {WIDTH_ACC{1'b0}};
      end
    end else begin : g_sum
      for (genvar i = 0; i < (P >> lv); i++) begin : g_add
        assign node_s[i] = g_lvl[lv-1].node_s[2*i] + g_lvl[lv-1].node_s[2*i+1];
      end
    end
  end

  assign group_sum_s = g_lvl[TL].node_s[0];

  if (WIDTH_OUT >= WIDTH_ACC) begin : g_extend
    assign narrow_s = WIDTH_OUT'(acc_r);
  end else if (SATURATE) begin : g_saturate
    localparam logic signed [WIDTH_ACC-1:0] OUT_MAX =
      {{(WIDTH_ACC-WIDTH_OUT+1){1'b0}}, {(WIDTH_OUT-1){1'b1}}};
    localparam logic signed [WIDTH_ACC-1:0] OUT_MIN =
      {{(WIDTH_ACC-WIDTH_OUT+1){1'b1}}, {(WIDTH_OUT-1){1'b0}}};
    // Clamp the full-precision sum into the signed output range.
    always_comb begin
      if (acc_r > OUT_MAX) begin
        narrow_s = {1'b0, {(WIDTH_OUT-1){1'b1}}};
      end else if (acc_r < OUT_MIN) begin
        narrow_s = {1'b1, {(WIDTH_OUT-1){1'b0}}};
      end else begin
        narrow_s = acc_r[WIDTH_OUT-1:0];
      end
    end
  end else begin : g_wrap
    assign narrow_s = acc_r[WIDTH_OUT-1:0];
  end

  // Sequencer: snapshot S on accepted start, fold F groups into acc, then publish the sample.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r  <= ST_IDLE;
      g_r      <= {GW{1'b0}};
      acc_r    <= {WIDTH_ACC{1'b0}};
      s_snap_r <= {(N*K){1'b0}};
      busy_r   <= 1'b0;
      valid_r  <= 1'b0;
      sample_r <= {WIDTH_OUT{1'b0}};
    end else begin
      valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            s_snap_r <= bus.S_matrix;
            acc_r    <= {WIDTH_ACC{1'b0}};
            g_r      <= {GW{1'b0}};
            busy_r   <= 1'b1;
            state_r  <= ST_ACCUM;
          end else begin
            busy_r   <= 1'b0;
          end
        end
        ST_ACCUM: begin
          acc_r <= acc_r + group_sum_s;
          if (g_r == GW'(F - 1)) begin
            g_r     <= {GW{1'b0}};
            state_r <= ST_OUT;
          end else begin
            g_r     <= g_r + GW'(1);
          end
        end
        ST_OUT: begin
          sample_r <= narrow_s;
          valid_r  <= 1'b1;
          busy_r   <= 1'b0;
          state_r  <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy         = busy_r;
  assign bus.sample       = sample_r;
  assign bus.sample_valid = valid_r;
endmodule
